// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus: control inputs, the shared 8-bit memory read port and the
// decode-side delivery (hit/pc/inst).
interface inst_fetcher_if;
    logic        rdy;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [7:0]  mem_din;
    logic        mem_en;
    logic [31:0] mem_a;
    logic        hit;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (
        input  rdy, stall, jump_en, jump_addr, mem_din,
        output mem_en, mem_a, hit, pc, inst
    );

    modport slave (
        output rdy, stall, jump_en, jump_addr, mem_din,
        input  mem_en, mem_a, hit, pc, inst
    );
endinterface

// File: rtl/inst_fetcher.sv
// Front-end fetch stage: assembles 32-bit little-endian words from an 8-bit port.
// Define ICACHE_EN to add a direct-mapped, one-word-per-line instruction cache.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef ICACHE_EN
    ,
    parameter int unsigned ICACHE_INDEX_BITS = 6
`endif
) (
    input logic            clk,
    input logic            rst,
    inst_fetcher_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3, S_OUT} state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic        hit_q, hit_d;
    logic        out_wait_q, out_wait_d;
    logic        blocked, complete;
    logic        mem_en_c;
    logic [31:0] mem_a_c;
    logic [31:0] word;

`ifdef ICACHE_EN
    localparam int unsigned Lines = 1 << ICACHE_INDEX_BITS;
    localparam int unsigned TagW  = 30 - ICACHE_INDEX_BITS;

    logic [Lines-1:0]             valid_q, valid_d;
    logic [TagW-1:0]              tag_mem  [Lines];
    logic [31:0]                  data_mem [Lines];
    logic [ICACHE_INDEX_BITS-1:0] idx;
    logic [TagW-1:0]              tag;
    logic                         cache_hit, cache_we;

    assign idx       = fpc_q[ICACHE_INDEX_BITS+1:2];
    assign tag       = fpc_q[31:ICACHE_INDEX_BITS+2];
    assign cache_hit = valid_q[idx] && (tag_mem[idx] == tag);
`endif

    // A delivered word may not be replaced while decode is stalling on it.
    assign blocked = hit_q && bus.stall;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        b3_d       = b3_q;
        hit_d      = hit_q;
        out_wait_d = out_wait_q;
        mem_en_c   = 1'b0;
        mem_a_c    = 32'h0;
        word       = 32'h0;
        complete   = 1'b0;
`ifdef ICACHE_EN
        cache_we   = 1'b0;
        valid_d    = valid_q;
`endif
        if (bus.rdy) begin
            hit_d = blocked;
            unique case (state_q)
                S_IDLE: state_d = S_B0;
                S_B0: begin
`ifdef ICACHE_EN
                    if (cache_hit) begin
                        word     = data_mem[idx];
                        complete = !blocked;
                    end else
`endif
                    begin
                        mem_en_c = 1'b1;
                        mem_a_c  = fpc_q;
                        state_d  = S_B1;
                    end
                end
                S_B1: begin
                    mem_en_c = 1'b1;
                    mem_a_c  = fpc_q + 32'd1;
                    b0_d     = bus.mem_din;
                    state_d  = S_B2;
                end
                S_B2: begin
                    mem_en_c = 1'b1;
                    mem_a_c  = fpc_q + 32'd2;
                    b1_d     = bus.mem_din;
                    state_d  = S_B3;
                end
                S_B3: begin
                    mem_en_c = 1'b1;
                    mem_a_c  = fpc_q + 32'd3;
                    b2_d     = bus.mem_din;
                    state_d  = S_OUT;
                end
                S_OUT: begin
                    // Byte 3 is only on mem_din for the first S_OUT cycle.
                    word = {out_wait_q ? b3_q : bus.mem_din, b2_q, b1_q, b0_q};
                    if (blocked) begin
                        if (!out_wait_q) b3_d = bus.mem_din;
                        out_wait_d = 1'b1;
                    end else begin
                        complete = 1'b1;
`ifdef ICACHE_EN
                        cache_we = 1'b1;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (complete) begin
                hit_d      = 1'b1;
                pc_d       = fpc_q;
                inst_d     = word;
                fpc_d      = fpc_q + 32'd4;
                state_d    = S_B0;
                out_wait_d = 1'b0;
            end

            if (bus.jump_en) begin
                hit_d      = 1'b0;
                fpc_d      = bus.jump_addr & ~32'h3;
                state_d    = S_B0;
                out_wait_d = 1'b0;
`ifdef ICACHE_EN
                cache_we   = 1'b0;
`endif
            end
`ifdef ICACHE_EN
            if (cache_we) valid_d[idx] = 1'b1;
`endif
        end else begin
            // Frozen: any partial word is refetched from byte 0 on resume.
            if (state_q != S_IDLE) state_d = S_B0;
            out_wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fpc_q      <= RESET_PC;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0000_0013;
            b0_q       <= 8'h0;
            b1_q       <= 8'h0;
            b2_q       <= 8'h0;
            b3_q       <= 8'h0;
            hit_q      <= 1'b0;
            out_wait_q <= 1'b0;
`ifdef ICACHE_EN
            valid_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            b3_q       <= b3_d;
            hit_q      <= hit_d;
            out_wait_q <= out_wait_d;
`ifdef ICACHE_EN
            valid_q    <= valid_d;
`endif
        end
    end

`ifdef ICACHE_EN
    always_ff @(posedge clk) begin
        if (!rst && cache_we) begin
            data_mem[idx] <= word;
            tag_mem[idx]  <= tag;
        end
    end
`endif

    assign bus.mem_en = mem_en_c;
    assign bus.mem_a  = mem_a_c;
    assign bus.hit    = hit_q;
    assign bus.pc     = pc_q;
    assign bus.inst   = inst_q;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed cycle script with literal expectations plus a
// rule-level delivery model (expected pc stream and memory words) checked every cycle.
module tb_inst_fetcher;
    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic clk;
    logic rst;
    inst_fetcher_if bus ();

    inst_fetcher #(.RESET_PC(ResetPc)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [4096];
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Byte-wide memory: data for the address presented one cycle earlier.
    always @(posedge clk) bus.mem_din <= bus.mem_en ? mem[bus.mem_a[11:0]] : 8'hEE;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[12'(a + 32'd3)], mem[12'(a + 32'd2)], mem[12'(a + 32'd1)], mem[a[11:0]]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Delivery model: every fresh hit must carry the next expected pc and its memory word.
    logic [31:0] exp_pc = ResetPc;
    logic        p_rst, p_rdy, p_stall, p_jump, p_hit;
    logic [31:0] p_jaddr, p_pc, p_inst;

    always @(negedge clk) begin
        if (chk_on) begin
            if (p_rst) begin
                chk("m_rst_hit", 32'(bus.hit), 32'h0);
                chk("m_rst_pc", bus.pc, 32'h0);
                chk("m_rst_inst", bus.inst, 32'h13);
                chk("m_rst_men", 32'(bus.mem_en), 32'h0);
                chk("m_rst_ma", bus.mem_a, 32'h0);
                exp_pc = ResetPc;
            end else if (!p_rdy || (p_hit && p_stall && !p_jump)) begin
                chk("m_hold_hit", 32'(bus.hit), 32'(p_hit));
                chk("m_hold_pc", bus.pc, p_pc);
                chk("m_hold_inst", bus.inst, p_inst);
            end else if (p_jump) begin
                chk("m_jump_hit", 32'(bus.hit), 32'h0);
                exp_pc = p_jaddr & ~32'h3;
            end else if (bus.hit) begin
                chk("m_del_pc", bus.pc, exp_pc);
                chk("m_del_inst", bus.inst, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (!bus.rdy) chk("m_frz_men", 32'(bus.mem_en), 32'h0);
            if (bus.mem_en) chk("m_ma_window", 32'((bus.mem_a - exp_pc) < 32'd4), 32'h1);
        end
        p_rst   = rst;
        p_rdy   = bus.rdy;
        p_stall = bus.stall;
        p_jump  = bus.jump_en;
        p_jaddr = bus.jump_addr;
        p_hit   = bus.hit;
        p_pc    = bus.pc;
        p_inst  = bus.inst;
    end

    task automatic drive(input int k);
        rst           = (k < -1) || (k == 43) || (k == 70) || (k == 71);
        bus.rdy       = !((k == 33) || (k == 34));
        bus.stall     = ((k >= 18) && (k <= 20)) || ((k >= 23) && (k <= 29)) || (k == 50);
        bus.jump_en   = 1'b1;
        case (k)
            12:      bus.jump_addr = 32'h0000_0103;
            40:      bus.jump_addr = 32'h0000_0040;
            50:      bus.jump_addr = 32'h0000_0200;
            51:      bus.jump_addr = 32'h0000_0300;
            52:      bus.jump_addr = 32'h0000_0305;
            58:      bus.jump_addr = 32'hFFFF_FFFE;
            83:      bus.jump_addr = 32'h0000_0000;
            default: begin
                bus.jump_en   = 1'b0;
                bus.jump_addr = 32'hDEAD_BEEF;
            end
        endcase
    endtask

    task automatic ex_out(input string nm, input logic h, input logic [31:0] p,
                          input logic [31:0] i);
        chk({nm, "_hit"}, 32'(bus.hit), 32'(h));
        if (h) begin
            chk({nm, "_pc"}, bus.pc, p);
            chk({nm, "_inst"}, bus.inst, i);
        end
    endtask

    task automatic ex_mem(input string nm, input logic en, input logic [31:0] a);
        chk({nm, "_men"}, 32'(bus.mem_en), 32'(en));
        if (en) chk({nm, "_ma"}, bus.mem_a, a);
    endtask

    task automatic expect_k(input int k);
        case (k)
            -1, 44: begin
                ex_out("reset", 1'b0, 32'h0, 32'h0);
                chk("reset_pc", bus.pc, 32'h0);
                chk("reset_inst", bus.inst, 32'h0000_0013);
                chk("reset_men", 32'(bus.mem_en), 32'h0);
                chk("reset_ma", bus.mem_a, 32'h0);
            end
            0, 1, 2, 3: ex_mem("first_bytes", 1'b1, 32'(k));
            4:  begin ex_mem("first_out", 1'b0, 32'h0); ex_out("first_out", 1'b0, 0, 0); end
            5:  begin ex_out("first_hit", 1'b1, 32'h0, 32'h0000_0013);
                      ex_mem("second_b0", 1'b1, 32'h4); end
            6:  ex_out("hit_pulse", 1'b0, 0, 0);
            10: ex_out("second_hit", 1'b1, 32'h4, 32'h0010_0093);
            13: begin ex_mem("jump_b0", 1'b1, 32'h100); ex_out("jump_drop", 1'b0, 0, 0); end
            18: ex_out("jump_hit", 1'b1, 32'h100, 32'hA6A7_A4A5);
            21: ex_out("stall_hold", 1'b1, 32'h100, 32'hA6A7_A4A5);
            22: ex_out("stall_release", 1'b0, 0, 0);
            23: ex_out("after_stall", 1'b1, 32'h104, 32'hA2A3_A0A1);
            28: begin ex_out("long_stall", 1'b1, 32'h104, 32'hA2A3_A0A1);
                      ex_mem("long_stall", 1'b0, 0); end
            31: ex_out("out_wait_word", 1'b1, 32'h108, 32'hAEAF_ACAD);
            33, 34: ex_mem("freeze", 1'b0, 0);
            35: ex_mem("resume", 1'b1, 32'h10C);
            40: ex_out("resume_hit", 1'b1, 32'h10C, 32'hAAAB_A8A9);
            45: ex_mem("post_reset", 1'b1, ResetPc);
            51: begin ex_out("jump_beats_stall", 1'b0, 0, 0);
                      ex_mem("jump_beats_stall", 1'b1, 32'h200); end
            53: ex_mem("last_jump_wins", 1'b1, 32'h304);
            58: ex_out("last_jump_hit", 1'b1, 32'h304, 32'hA2A3_A0A1);
            64: begin
                ex_out("wrap_hit", 1'b1, 32'hFFFF_FFFC, 32'h5A5B_5859);
`ifndef ICACHE_EN
                ex_mem("wrap_next", 1'b1, 32'h0);
`endif
            end
`ifdef ICACHE_EN
            84: begin ex_mem("loop_cached", 1'b0, 0); ex_out("loop_cached", 1'b0, 0, 0); end
            85: ex_out("loop_hit0", 1'b1, 32'h0, 32'h0000_0013);
            86: begin ex_out("loop_hit4", 1'b1, 32'h4, 32'h0010_0093);
                      ex_mem("loop_miss8", 1'b1, 32'h8); end
`else
            84: begin ex_mem("loop_refetch", 1'b1, 32'h0); ex_out("loop_refetch", 1'b0, 0, 0); end
            89: ex_out("loop_hit0", 1'b1, 32'h0, 32'h0000_0013);
`endif
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 8; i++) mem[i] = prog[i];
        rst           = 1'b1;
        bus.rdy       = 1'b1;
        bus.stall     = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 32'h0;
        bus.mem_din   = 8'hEE;
        for (int k = -3; k <= 90; k++) begin
            @(posedge clk);
            #1;
            drive(k);
            if (k == -2) chk_on = 1'b1;
            @(negedge clk);
            expect_k(k);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
